// File: rtl/mem_definitions.sv
// rtl/mem_definitions.sv - shared memory access types for the data-memory path
package mem_definitions;

  typedef enum logic [2:0] {
    BYTE   = 3'd0,
    HALF   = 3'd1,
    WORD   = 3'd2,
    BYTE_U = 3'd3,
    HALF_U = 3'd4
  } mem_mask_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, load extension and alignment check
module dmem_lane_align
  import mem_definitions::*;
(
  input  logic [1:0]  offset,
  input  mem_mask_t   mask,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rword >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    load_data   = rword;
    misalign    = 1'b0;
    case (mask)
      BYTE, BYTE_U: begin
        byte_en     = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {{24{byte_sel[7] & (mask == BYTE)}}, byte_sel};
      end
      HALF, HALF_U: begin
        misalign    = offset[0];
        byte_en     = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = {{16{half_sel[15] & (mask == HALF)}}, half_sel};
      end
      WORD: begin
        misalign = (offset != 2'b00);
        byte_en  = 4'b1111;
      end
      // Unencoded mask values never reach the array
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - stalling data-memory responder with word array
module dmem_responder
  import mem_definitions::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  mem_mask_t   req_mask,
  output logic        stall_mem,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misalign_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W+1:0]  addr_q;
  logic [31:0]       wdata_q;
  mem_mask_t         mask_q;
  logic              read_q, write_q;
  logic [31:0]       rword_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, commit, err;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lanes, load_data;
  logic              misalign;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:IDX_W+2];
  assign idx = addr_q[IDX_W+1:2];
  assign err = misalign | (read_q & write_q);

  dmem_lane_align u_lane_align (
    .offset      (addr_q[1:0]),
    .mask        (mask_q),
    .wdata       (wdata_q),
    .rword       (rword_q),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data),
    .misalign    (misalign)
  );

  always_comb begin
    state_next   = state;
    stall_mem    = 1'b0;
    rvalid       = 1'b0;
    misalign_err = 1'b0;
    rdata        = rdata_q;
    accept       = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (req_read || req_write) begin
          stall_mem  = 1'b1;
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_mem = 1'b1;
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rvalid       = read_q;
        misalign_err = err;
        if (read_q) rdata = err ? 32'h0 : load_data;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= 32'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      mask_q  <= WORD;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= req_addr[IDX_W+1:0];
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
        read_q  <= req_read;
        write_q <= req_write;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == RESP && read_q) rdata_q <= rdata;
    end
  end

  // Array is not reset; the rst_n gate keeps an aborted store from landing
  always_ff @(posedge clk) begin
    if (rst_n && commit && !err) begin
      if (write_q) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem[idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
        end
      end
      if (read_q) rword_q <= mem[idx];
    end
  end

endmodule
